data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-mapped data-memory responder servicing the CPU's load/store port through a valid/ready request/response handshake. It decodes the RV32I funct3 width and signedness, applies byte-lane write masks, sign- or zero-extends read data, and inserts a programmable number of wait states. It is the responder side of the data path the multi-cycle and pipelined cores will use in place of a zero-latency combinational memory.

## Interface
Parameters:
- DEPTH_WORDS, 1024: storage depth in 32-bit words; must be a power of two.
- WAIT_STATES, 1: extra cycles between request acceptance and response; 0 to 15 allowed.
- BASE_ADDR, 32'h1001_0000: byte address of word 0.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_func3  in  3  RV32I funct3 of the load or store.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access fault.

## Operation
- States are IDLE, WAIT and RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid: latch we, addr, wdata and func3, and load wait_cnt=WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, otherwise RESP.
- **WAIT**
  - req_ready=0.
  - wait_cnt decrements each cycle.
  - When wait_cnt reaches 1, the next state is RESP.
- **RESP**
  - rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On rsp_ready the next state is IDLE.
- **Address decode**
  - offset = addr − BASE_ADDR.
  - Word index = offset[log2(DEPTH_WORDS)+1:2].
  - If offset ≥ 4·DEPTH_WORDS (unsigned, so addresses below BASE_ADDR also fail), the access gives err=1.
- **Loads**
  - funct3 000 = lb, 001 = lh, 010 = lw, 100 = lbu, 101 = lhu.
  - Byte lanes are little-endian, selected by addr[1:0].
  - lb/lh sign-extend; lbu/lhu zero-extend.
- **Stores**
  - funct3 000 = sb, 001 = sh, 010 = sw.
  - sb writes the byte lane addr[1:0] from wdata[7:0].
  - sh writes lanes {addr[1],0} and {addr[1],1} from wdata[15:0].
  - Untouched lanes keep their contents.
- **Illegal funct3** (load 011, 110 or 111; store with funct3 ≥ 011): err=1, no write, rdata=0.
- **Write commit**: the write occurs on the edge that enters RESP, and only if err=0. Exactly one write is made per accepted store.
- **Storage**: contents are not reset. Reads return the contents at RESP entry.

## Timing
- **Reset values**
  - While rst=1: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, wait_cnt=0.
  - req_ready rises in the first cycle after rst deasserts.
- **Latency**: rsp_valid asserts WAIT_STATES+1 cycles after the accepting edge. With WAIT_STATES=0, rsp_valid asserts on the very next cycle.
- **Throughput**: one request per WAIT_STATES+2 cycles when rsp_ready is held at 1. req_ready is 0 throughout WAIT and RESP.
- **Back-to-back**: the response handshake and a new request acceptance never overlap. The new request is accepted in the IDLE cycle that follows.
- **Backpressure**: while rsp_ready=0 in RESP, all outputs are frozen.
- **Reset mid-operation**: the pending transaction is discarded. A store not yet committed (state WAIT) never writes.

## Configuration
- **MEM_MISALIGN_TRAP_EN defined**:
  - lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠0, give rsp_err=1, rsp_rdata=0 and no write.
- **MEM_MISALIGN_TRAP_EN undefined**:
  - Misaligned low address bits are forced to natural alignment: halfword accesses clear addr[0]; word accesses clear addr[1:0].
  - Misalignment never raises rsp_err.

## Structure
- **Package mem_pkg** holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum mem_state_t (IDLE, WAIT, RESP).
  - WAIT_CNT_W = 4.
- **Sub-module mem_lane_align** (combinational):
  - Inputs: addr[1:0], funct3, wdata, read word.
  - Outputs: 4-bit byte write mask, lane-shifted write data, extended read data, misalignment flag.
- **Top module** holds the FSM, the wait counter, the request latch and the storage array.

## Test plan
- **Reset mid-operation**: sw 0xDEADBEEF at BASE_ADDR, then assert rst during WAIT → after release, lw at BASE_ADDR returns the prior contents; req_ready=0 while rst=1.
- **Byte store and sign-extension**: sw 0x11223344 at BASE_ADDR+4; then sb 0xF0 at BASE_ADDR+5 → lw returns 0x1122F044; lb at +5 returns 0xFFFFFFF0; lbu at +5 returns 0x000000F0.
- **Halfword sign-extension**: sh 0x8001 at BASE_ADDR+6 → lh at +6 returns 0xFFFF8001; lhu at +6 returns 0x00008001.
- **Latency and backpressure**: with WAIT_STATES=3, rsp_valid rises exactly 4 cycles after acceptance; with rsp_ready held 0 for 5 cycles, rsp_rdata stays stable and req_ready stays 0.
- **Faults**:
  - lw at BASE_ADDR−4 → rsp_err=1, rdata=0.
  - Store with funct3=011 → rsp_err=1 and memory is unchanged.
- **Misalignment**: lw at BASE_ADDR+2 → with MEM_MISALIGN_TRAP_EN, rsp_err=1; without it, the result equals lw at BASE_ADDR.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 encodings, responder state type and counter width.
package mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam int WAIT_CNT_W = 4;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane mask, write-data shift and load extension for one word access.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [2:0]  func3,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [3:0]  mask,
    output logic [31:0] wlane,
    output logic [31:0] rdata,
    output logic        misalign
);
    logic        is_h;
    logic        is_w;
    logic [1:0]  lane;
    logic [31:0] shifted;

    assign is_h     = func3[1:0] == F3_H[1:0];
    assign is_w     = func3[1:0] == F3_W[1:0];
    assign misalign = (is_h & addr[0]) | (is_w & |addr);
    // Misaligned accesses fall back to the naturally aligned lane.
    assign lane     = is_w ? 2'b00 : is_h ? {addr[1], 1'b0} : addr;
    assign shifted  = word >> {lane, 3'b000};
    assign mask     = (is_w ? 4'b1111 : is_h ? 4'b0011 : 4'b0001) << lane;
    assign wlane    = wdata << {lane, 3'b000};
    assign rdata    = is_w ? shifted
                    : is_h ? {{16{~func3[2] & shifted[15]}}, shifted[15:0]}
                    :        {{24{~func3[2] & shifted[7]}}, shifted[7:0]};
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready data memory with wait states and RV32I load/store widths.
// Define MEM_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of aligning them.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    mem_state_t          state, next;
    logic [WAIT_CNT_W-1:0] cnt;
    logic                l_we;
    logic [31:0]         l_addr, l_wdata;
    logic [2:0]          l_f3;
    logic                c_we;
    logic [31:0]         c_addr, c_wdata, off;
    logic [2:0]          c_f3;
    logic [AW-1:0]       idx;
    logic                enter, bad_f3, err, misalign;
    logic [3:0]          mask;
    logic [31:0]         wlane, lane_rdata;
    logic [31:0]         mem [DEPTH_WORDS];

    // With zero wait states RESP is entered on the accepting edge, before the latch holds the request.
    assign c_we    = (state == IDLE) ? req_we    : l_we;
    assign c_addr  = (state == IDLE) ? req_addr  : l_addr;
    assign c_wdata = (state == IDLE) ? req_wdata : l_wdata;
    assign c_f3    = (state == IDLE) ? req_func3 : l_f3;
    assign off     = c_addr - BASE_ADDR;
    assign idx     = off[AW+1:2];
    assign bad_f3  = c_we ? (c_f3 > F3_W)
                          : !(c_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign err     = bad_f3 | (off >= 32'(4 * DEPTH_WORDS)) | (TRAP & misalign);
    assign req_ready = (state == IDLE) & ~rst;
    assign rsp_valid = state == RESP;

    mem_lane_align u_align (
        .addr     (off[1:0]),
        .func3    (c_f3),
        .wdata    (c_wdata),
        .word     (mem[idx]),
        .mask     (mask),
        .wlane    (wlane),
        .rdata    (lane_rdata),
        .misalign (misalign)
    );

    always_comb begin
        next  = state;
        enter = 1'b0;
        unique case (state)
            IDLE: if (req_valid) begin
                next  = (WAIT_STATES == 0) ? RESP : WAIT;
                enter = WAIT_STATES == 0;
            end
            WAIT: if (cnt == WAIT_CNT_W'(1)) begin
                next  = RESP;
                enter = 1'b1;
            end
            RESP: if (rsp_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            l_we      <= 1'b0;
            l_addr    <= '0;
            l_wdata   <= '0;
            l_f3      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && req_valid) begin
                l_we    <= req_we;
                l_addr  <= req_addr;
                l_wdata <= req_wdata;
                l_f3    <= req_func3;
                cnt     <= WAIT_CNT_W'(WAIT_STATES);
            end else if (state == WAIT) begin
                cnt <= cnt - WAIT_CNT_W'(1);
            end
            if (enter) begin
                rsp_rdata <= (err | c_we) ? '0 : lane_rdata;
                rsp_err   <= err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enter && c_we && !err && !rst)
            for (int i = 0; i < 4; i++)
                if (mask[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed load/store vectors checked against a byte-level memory model.
module tb_data_mem_responder;
    localparam int unsigned W     = 3;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  req_func3 = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [31:0] rsp_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    logic [7:0] mem_m [int unsigned];

    function automatic void model(input logic we, input logic [31:0] a, input logic [31:0] d,
                                  input logic [2:0] f, output logic [31:0] rd, output logic er);
        logic [31:0] off;
        logic [31:0] v;
        int unsigned sz;
        off = a - BASE;
        sz  = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        er  = (off >= 32'(4 * DEPTH)) || (we ? (f > 3'd2) : (f == 3'd3 || f >= 3'd6));
`ifdef MEM_MISALIGN_TRAP_EN
        if (off % sz != 0) er = 1'b1;
`endif
        off = off - off % sz;
        rd  = '0;
        if (er) return;
        if (we) begin
            for (int i = 0; i < int'(sz); i++) mem_m[off + i] = d[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < int'(sz); i++) v = v | (32'(mem_m[off + i]) << (8 * i));
            if (sz == 1 && !f[2])      rd = {{24{v[7]}}, v[7:0]};
            else if (sz == 2 && !f[2]) rd = {{16{v[15]}}, v[15:0]};
            else                       rd = v;
        end
    endfunction

    logic        pend = 1'b0, have = 1'b0;
    logic        p_we;
    logic [31:0] p_addr, p_wdata, e_rd;
    logic [2:0]  p_f3;
    logic        e_er;
    int          acc;

    // Compare process: every response cycle is checked against the model's expectation.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_rsp_err", 32'(rsp_err), 0);
            pend = 1'b0;
            have = 1'b0;
        end else begin
            if (rsp_valid) begin
                chk("rsp_req_ready", 32'(req_ready), 0);
                if (!pend) chk("rsp_without_req", 32'(rsp_valid), 0);
                else begin
                    if (!have) begin
                        model(p_we, p_addr, p_wdata, p_f3, e_rd, e_er);
                        have = 1'b1;
                        chk("latency", 32'(cyc - acc), W + 1);
                    end
                    chk("model_rdata", rsp_rdata, e_rd);
                    chk("model_err", 32'(rsp_err), 32'(e_er));
                    if (rsp_ready) begin
                        pend = 1'b0;
                        have = 1'b0;
                    end
                end
            end else if (pend) begin
                chk("wait_req_ready", 32'(req_ready), 0);
            end
            if (req_valid && req_ready) begin
                pend = 1'b1; p_we = req_we; p_addr = req_addr; p_wdata = req_wdata; p_f3 = req_func3;
                acc = cyc;
            end
        end
    end

    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       input int stall, output logic [31:0] rd, output logic er);
        int n;
        req_we = we; req_addr = a; req_wdata = d; req_func3 = f; req_valid = 1'b1;
        rsp_ready = (stall == 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 50);
        if (!req_ready) chk("accept_timeout", 32'(req_ready), 1);
        @(posedge clk); #1 req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
        if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 1);
        rd = rsp_rdata;
        er = rsp_err;
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1 rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic t(input string name, input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f, input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd;
        logic er;
        txn(we, a, d, f, 0, rd, er);
        chk({name, "_rdata"}, rd, exp_rd);
        chk({name, "_err"}, 32'(er), 32'(exp_er));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic er;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 1);
        @(posedge clk); #1;
        t("sw_base", 1'b1, BASE, 32'h0102_0304, 3'b010, 32'h0, 1'b0);
        // Store accepted, then reset while it is still waiting: it must never land.
        req_we = 1'b1; req_addr = BASE; req_wdata = 32'hDEAD_BEEF; req_func3 = 3'b010; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_midrst", 32'(req_ready), 1);
        @(posedge clk); #1;
        t("lw_after_rst", 1'b0, BASE, 32'h0, 3'b010, 32'h0102_0304, 1'b0);
        t("sw_4", 1'b1, BASE + 4, 32'h1122_3344, 3'b010, 32'h0, 1'b0);
        t("sb_5", 1'b1, BASE + 5, 32'hFFFF_FFF0, 3'b000, 32'h0, 1'b0);
        t("lw_4", 1'b0, BASE + 4, 32'h0, 3'b010, 32'h1122_F044, 1'b0);
        t("lb_5", 1'b0, BASE + 5, 32'h0, 3'b000, 32'hFFFF_FFF0, 1'b0);
        t("lbu_5", 1'b0, BASE + 5, 32'h0, 3'b100, 32'h0000_00F0, 1'b0);
        t("sh_6", 1'b1, BASE + 6, 32'h0000_8001, 3'b001, 32'h0, 1'b0);
        t("lh_6", 1'b0, BASE + 6, 32'h0, 3'b001, 32'hFFFF_8001, 1'b0);
        t("lhu_6", 1'b0, BASE + 6, 32'h0, 3'b101, 32'h0000_8001, 1'b0);
        txn(1'b0, BASE + 4, 32'h0, 3'b010, 5, rd, er);
        chk("stall_rdata", rd, 32'h8001_F044);
        t("lw_below", 1'b0, BASE - 4, 32'h0, 3'b010, 32'h0, 1'b1);
        t("st_f3_011", 1'b1, BASE + 4, 32'h0, 3'b011, 32'h0, 1'b1);
        t("lw_unchanged", 1'b0, BASE + 4, 32'h0, 3'b010, 32'h8001_F044, 1'b0);
        t("ld_f3_110", 1'b0, BASE + 4, 32'h0, 3'b110, 32'h0, 1'b1);
        t("sw_top", 1'b1, BASE + 4 * DEPTH - 4, 32'hCAFE_0042, 3'b010, 32'h0, 1'b0);
        t("lbu_top", 1'b0, BASE + 4 * DEPTH - 1, 32'h0, 3'b100, 32'h0000_00CA, 1'b0);
        t("lw_past_end", 1'b0, BASE + 4 * DEPTH, 32'h0, 3'b010, 32'h0, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
        t("lw_mis", 1'b0, BASE + 2, 32'h0, 3'b010, 32'h0, 1'b1);
        t("lh_mis", 1'b0, BASE + 5, 32'h0, 3'b001, 32'h0, 1'b1);
`else
        t("lw_mis", 1'b0, BASE + 2, 32'h0, 3'b010, 32'h0102_0304, 1'b0);
        t("lh_mis", 1'b0, BASE + 5, 32'h0, 3'b001, 32'hFFFF_F044, 1'b0);
`endif
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
